// File: rtl/spi_bridge.sv
// SPI mode-0 slave front end: synchronises sclk/cs_n/mosi into clk, shifts bytes in and out MSB first.
// Latency: byte_sync/data_in appear 1 clk after the synchronised 8th sclk rise; tx reload 2 clks after byte_sync.
// Backpressure: none; the master must respect the minimum sclk phase width, and the decoder answers within 2 clks.
module spi_bridge #(
    parameter int SYNC_STAGES = 2   // legal range 2..3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       byte_sync,
    output logic [7:0] data_in,
    input  logic [7:0] data_out
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Synchroniser chains; the MSB of each vector is the synchronised value.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync_r;

    // Marks how far genuine pin samples have propagated since reset release.
    logic [SYNC_STAGES-1:0] fill;

    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;
    logic       sync_ok;

    logic       sclk_d;
    logic       cs_d;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_fall;
    logic       cs_rise;

    logic       armed;
    logic       frame_start;

    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [1:0] ld_pipe;
    logic [7:0] rx_next;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_r[SYNC_STAGES-1];
    assign sync_ok = fill[SYNC_STAGES-1];

    // Resynchronise the three SPI pins; idle-level reset values avoid false edges on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync   <= '0;
            cs_sync     <= '1;
            mosi_sync_r <= '0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
        end
    end

    // Track when the synchronisers hold real pin samples rather than reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
        end else begin
            fill <= {fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Delayed copies of the synchronised clock and select for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    // A frame may only start once cs_n has been genuinely seen high after reset,
    // so a select already low at reset release cannot open a frame mid-transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (sync_ok && cs_s) begin
            armed <= 1'b1;
        end
    end

    assign frame_start = cs_fall & armed;
    assign rx_next     = {rx_shift[6:0], mosi_s};

    // Frame state: opens on a qualified select fall, closes on select rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (frame_start) state <= ST_ACTIVE;
                ST_ACTIVE: if (cs_rise)     state <= ST_IDLE;
                default:                    state <= ST_IDLE;
            endcase
        end
    end

    // Receive path: bit counter and shift register; select rise beats a coincident sclk rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
        end else if (state == ST_IDLE) begin
            if (frame_start) begin
                bit_cnt  <= 3'd0;
                rx_shift <= 8'h00;
            end
        end else if (cs_rise) begin
            bit_cnt <= 3'd0;
        end else if (sclk_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 3'd1;
        end
    end

    // Completed-byte capture and the single-cycle byte_sync strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_in   <= 8'h00;
            byte_sync <= 1'b0;
        end else begin
            byte_sync <= 1'b0;
            if (state == ST_ACTIVE && !cs_rise && sclk_rise && bit_cnt == 3'd7) begin
                data_in   <= rx_next;
                byte_sync <= 1'b1;
            end
        end
    end

    // Delay byte_sync by two clks so the decoder's registered reply is ready for reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_pipe <= 2'b00;
        end else begin
            ld_pipe <= {ld_pipe[0], byte_sync};
        end
    end

    // Transmit path: load at frame start, reload after each byte, shift on sclk fall
    // except at a byte boundary so the freshly loaded MSB is presented first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= 8'h00;
        end else if (state == ST_IDLE) begin
            if (frame_start) tx_shift <= data_out;
        end else if (!cs_rise) begin
            if (ld_pipe[1]) begin
                tx_shift <= data_out;
            end else if (sclk_fall && bit_cnt != 3'd0) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    // Registered serial output, forced low outside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso <= 1'b0;
        end else begin
            miso <= (state == ST_ACTIVE) ? tx_shift[7] : 1'b0;
        end
    end

endmodule
